image_rx_buffer: RTL and testbench
==================================

Name: image_rx_buffer

Overview:
- Consumes the byte stream produced by the SPI peripheral (rx_data/rx_valid).
- Frames one binary input image behind a start byte and packs the pixels into a row-addressed bitmap.
- Presents the full image to the BNN inference core through a ready/consume handshake and a registered row-read port.
- Sits directly downstream of the SPI receiver and upstream of the first binary-conv layer.

Parameters:
- IMG_WIDTH, 32, pixels per row; must be a multiple of 8.
- IMG_HEIGHT, 32, rows per image.
- START_BYTE, 8'hA5, header byte that opens a frame.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- rx_data  in  8  byte from SPI receiver
- rx_valid  in  1  byte-valid from SPI receiver; may be a pulse or a level
- clear  in  1  synchronous abort: discard frame, return to IDLE
- img_consume  in  1  one-cycle pulse from inference core: image used, release buffer
- rd_row  in  $clog2(IMG_HEIGHT)  row address for read port
- rd_data  out  IMG_WIDTH  registered row word
- img_ready  out  1  complete image held
- busy  out  1  frame load in progress
- overflow  out  1  sticky: byte arrived while FULL
- byte_count  out  $clog2(IMG_WIDTH*IMG_HEIGHT/8+1)  payload bytes stored in the current frame

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE.
  - img_ready, busy, overflow, byte_count = 0.
  - rd_data = 0; the rx_valid history register = 0.
  - Bitmap contents are not cleared.
- Byte event:
  - rx_valid is registered each cycle.
  - A byte event is a rising edge (rx_valid=1, previous=0), detected one cycle after rx_valid rises.
  - rx_data is sampled in the same cycle rx_valid is first seen high.
  - A level held high produces exactly one event.
- Payload size: NBYTES = IMG_WIDTH*IMG_HEIGHT/8 (128 at defaults).
- IDLE state:
  - Event with byte == START_BYTE -> LOAD, byte_count = 0, busy = 1.
  - Any other byte is dropped silently.
- LOAD state:
  - Each event stores the byte at pixel index p = 8*byte_count.
  - Byte bit 7 is pixel p, bit 0 is pixel p+7 (MSB first).
  - Pixel p is stored at row p / IMG_WIDTH, column p % IMG_WIDTH.
  - Row word bit IMG_WIDTH-1-c holds column c, so column 0 is the MSB.
  - byte_count increments after each store.
  - On the event that stores byte NBYTES-1: next cycle state = FULL, busy = 0, img_ready = 1, byte_count = NBYTES.
  - START_BYTE inside the payload is data, not a resync.
- FULL state:
  - Events are dropped and set overflow = 1; bitmap is unchanged.
  - img_consume -> IDLE, img_ready = 0, overflow = 0, byte_count = 0.
  - img_consume is ignored in IDLE and LOAD.
- Simultaneous events:
  - Byte event and img_consume in the same cycle while FULL: consume wins; the byte is dropped and does not set overflow.
  - clear has priority over every other input: state -> IDLE, img_ready = busy = overflow = 0, byte_count = 0.
  - Bitmap contents are retained through clear.
- Read port:
  - rd_data <= row[rd_row] on every clk; 1-cycle latency; valid in any state.
  - During LOAD it returns partial or stale data.
  - rd_row >= IMG_HEIGHT returns 0.
- Reset mid-frame behaves exactly as clear and also zeroes rd_data.

Decomposition:
- Package bnn_img_pkg holds:
  - IMG_WIDTH, IMG_HEIGHT, NBYTES, BYTES_PER_ROW, START_BYTE constants.
  - typedef enum logic [1:0] {IDLE, LOAD, FULL} img_state_t.
  - typedef logic [IMG_WIDTH-1:0] img_row_t.
- Sub-module img_row_mem: IMG_HEIGHT x IMG_WIDTH register array.
  - Byte-lane write port: row, byte lane, data.
  - Registered read port.
- Top level holds edge detect, FSM, counters and flags.

Test Plan:
1. Reset, then A5 followed by 128 bytes with byte k = k -> img_ready = 1 one cycle after last event, byte_count = 128; rd_row 0 gives 32'h00010203, rd_row 31 gives 32'h7C7D7E7F after 1-cycle latency.
2. Bytes 3C, 00 before A5 -> state remains IDLE, busy = 0, byte_count = 0; then a full frame loads normally.
3. Full frame, then extra byte FF -> overflow = 1 and row 0 unchanged; img_consume pulse -> img_ready = 0, overflow = 0, IDLE; next frame of all 8'hFF reads back 32'hFFFFFFFF on every row.
4. rx_valid held high for 5 cycles per byte -> exactly one store per byte, byte_count increments by 1 per byte.
5. A5 + 40 bytes, then clear (or rst_n low for one cycle) -> busy = 0, byte_count = 0; a new A5 + 128-byte frame completes and reads back correctly.
6. FULL state with byte event and img_consume in the same cycle -> overflow stays 0, state IDLE; a following A5 opens a new frame.

Source files
------------

// File: rtl/bnn_img_pkg.sv
// Shared constants and types for the binary input-image receive path.
package bnn_img_pkg;
  localparam int unsigned IMG_WIDTH     = 32;
  localparam int unsigned IMG_HEIGHT    = 32;
  localparam int unsigned NBYTES        = IMG_WIDTH * IMG_HEIGHT / 8;
  localparam int unsigned BYTES_PER_ROW = IMG_WIDTH / 8;
  localparam logic [7:0]  START_BYTE    = 8'hA5;

  typedef enum logic [1:0] {IDLE, LOAD, FULL} img_state_t;
  typedef logic [IMG_WIDTH-1:0] img_row_t;
endpackage

// File: rtl/img_row_mem.sv
// Row-addressed bitmap: byte-lane write port and registered row read port.
module img_row_mem #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned RW    = $clog2(DEPTH),
  parameter int unsigned LW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [RW-1:0]    wr_row,
  input  logic [LW-1:0]    wr_lane,
  input  logic [7:0]       wr_byte,
  input  logic [RW-1:0]    rd_row,
  output logic [WIDTH-1:0] rd_data
);
  localparam int unsigned LANES = WIDTH / 8;

  logic [WIDTH-1:0] mem [DEPTH];

  // Lane 0 is the leftmost byte of the row (columns 0..7 in the top bits).
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_row) < DEPTH)) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if (32'(wr_lane) == l)
          mem[wr_row][WIDTH-1-8*l -: 8] <= wr_byte;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      rd_data <= '0;
    else if (32'(rd_row) < DEPTH)
      rd_data <= mem[rd_row];
    else
      rd_data <= '0;
  end
endmodule

// File: rtl/image_rx_buffer.sv
// Frames a start-byte-prefixed binary image from the SPI byte stream into a
// row bitmap and hands it to the inference core via ready/consume.
module image_rx_buffer #(
  parameter int unsigned IMG_WIDTH  = bnn_img_pkg::IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT = bnn_img_pkg::IMG_HEIGHT,
  parameter logic [7:0]  START_BYTE = bnn_img_pkg::START_BYTE
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [7:0]                                    rx_data,
  input  logic                                          rx_valid,
  input  logic                                          clear,
  input  logic                                          img_consume,
  input  logic [$clog2(IMG_HEIGHT)-1:0]                 rd_row,
  output logic [IMG_WIDTH-1:0]                          rd_data,
  output logic                                          img_ready,
  output logic                                          busy,
  output logic                                          overflow,
  output logic [$clog2(IMG_WIDTH*IMG_HEIGHT/8+1)-1:0]   byte_count
);
  import bnn_img_pkg::img_state_t;
  import bnn_img_pkg::IDLE;
  import bnn_img_pkg::LOAD;
  import bnn_img_pkg::FULL;

  localparam int unsigned NBYTES = IMG_WIDTH * IMG_HEIGHT / 8;
  localparam int unsigned BPR    = IMG_WIDTH / 8;
  localparam int unsigned RW     = $clog2(IMG_HEIGHT);
  localparam int unsigned CW     = $clog2(NBYTES + 1);
  localparam int unsigned LW     = (BPR > 1) ? $clog2(BPR) : 1;

  img_state_t      state;
  logic            rv_q;
  logic            evt;
  logic [7:0]      evt_byte;
  logic            wr_en;
  logic [RW-1:0]   wr_row;
  logic [LW-1:0]   wr_lane;

  // Byte is captured on the first high cycle; the event fires one cycle later,
  // so a held level yields exactly one event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rv_q     <= 1'b0;
      evt      <= 1'b0;
      evt_byte <= '0;
    end else begin
      rv_q <= rx_valid;
      evt  <= rx_valid && !rv_q;
      if (rx_valid && !rv_q)
        evt_byte <= rx_data;
    end
  end

  always_comb begin
    wr_en   = rst_n && !clear && evt && (state == LOAD);
    wr_row  = RW'(byte_count / BPR);
    wr_lane = LW'(byte_count % BPR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state      <= IDLE;
      img_ready  <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      byte_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (evt && (evt_byte == START_BYTE)) begin
            state      <= LOAD;
            busy       <= 1'b1;
            byte_count <= '0;
          end
        end
        LOAD: begin
          if (evt) begin
            if (byte_count == CW'(NBYTES - 1)) begin
              state      <= FULL;
              busy       <= 1'b0;
              img_ready  <= 1'b1;
              byte_count <= CW'(NBYTES);
            end else begin
              byte_count <= byte_count + CW'(1);
            end
          end
        end
        FULL: begin
          // Consume outranks a coincident byte, which is then not an overflow.
          if (img_consume) begin
            state      <= IDLE;
            img_ready  <= 1'b0;
            overflow   <= 1'b0;
            byte_count <= '0;
          end else if (evt) begin
            overflow <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  img_row_mem #(
    .WIDTH (IMG_WIDTH),
    .DEPTH (IMG_HEIGHT),
    .RW    (RW),
    .LW    (LW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_lane (wr_lane),
    .wr_byte (evt_byte),
    .rd_row  (rd_row),
    .rd_data (rd_data)
  );
endmodule

// File: tb/tb_image_rx_buffer.sv
// Scoreboard bench for image_rx_buffer against a pixel-level frame model.
module tb_image_rx_buffer;
  localparam int W  = 32;
  localparam int H  = 32;
  localparam int NB = W * H / 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        clear = 1'b0;
  logic        img_consume = 1'b0;
  logic [4:0]  rd_row = '0;
  logic [31:0] rd_data;
  logic        img_ready, busy, overflow;
  logic [7:0]  byte_count;

  always #5 clk = ~clk;

  image_rx_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .clear       (clear),
    .img_consume (img_consume),
    .rd_row      (rd_row),
    .rd_data     (rd_data),
    .img_ready   (img_ready),
    .busy        (busy),
    .overflow    (overflow),
    .byte_count  (byte_count)
  );

  typedef struct {
    bit          is_row;
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  bit   req = 1'b0;

  // Reference model: 0 = waiting for header, 1 = loading, 2 = image held
  logic [W-1:0] m_rows [H];
  int           m_state = 0;
  int           m_cnt = 0;
  bit           m_ovf = 1'b0;

  function automatic void model_event(logic [7:0] b);
    int p;
    case (m_state)
      0: if (b == 8'hA5) begin m_state = 1; m_cnt = 0; end
      1: begin
        for (int i = 0; i < 8; i++) begin
          p = 8 * m_cnt + i;
          m_rows[p / W][W - 1 - (p % W)] = b[7 - i];
        end
        m_cnt++;
        if (m_cnt == NB) m_state = 2;
      end
      default: m_ovf = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = {21'b0, (m_state == 2), (m_state == 1), m_ovf, 8'(m_cnt)};
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a request seen at a posedge is resolved at the following negedge.
  initial begin
    bit   p;
    exp_t e;
    forever begin
      @(posedge clk);
      p = req;
      @(negedge clk);
      if (p) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL scoreboard_empty: got response expected none");
        end else begin
          e = exp_q.pop_front();
          if (e.is_row) chk(e.name, rd_data, e.exp);
          else chk(e.name, {21'b0, img_ready, busy, overflow, byte_count}, e.exp);
        end
      end
    end
  end

  task automatic expect_status(input string nm);
    exp_t e;
    e.is_row = 1'b0; e.name = nm; e.exp = model_status();
    exp_q.push_back(e);
    req = 1'b1; tick(); req = 1'b0;
  endtask

  task automatic expect_row(input int r, input string nm, input logic [31:0] v);
    exp_t e;
    e.is_row = 1'b1; e.name = nm; e.exp = v;
    exp_q.push_back(e);
    rd_row = 5'(r);
    req = 1'b1; tick(); req = 1'b0;
  endtask

  task automatic check_all_rows(input string nm);
    for (int r = 0; r < H; r++) expect_row(r, nm, m_rows[r]);
  endtask

  task automatic send(input logic [7:0] b, input int hold);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    for (int i = 1; i < hold; i++) begin
      rx_data = 8'($urandom);
      tick();
    end
    rx_valid = 1'b0;
    rx_data = 8'($urandom);
    repeat ($urandom_range(1, 2)) tick();
    model_event(b);
  endtask

  // kind: 0 = byte k is k, 1 = random, 2 = all FF
  task automatic send_frame(input int kind, input int nbytes);
    logic [7:0] b;
    send(8'hA5, $urandom_range(1, 3));
    for (int k = 0; k < nbytes; k++) begin
      b = (kind == 0) ? 8'(k) : (kind == 2) ? 8'hFF : 8'($urandom);
      send(b, $urandom_range(1, 3));
    end
  endtask

  task automatic consume();
    img_consume = 1'b1; tick(); img_consume = 1'b0;
    if (m_state == 2) begin m_state = 0; m_ovf = 1'b0; m_cnt = 0; end
  endtask

  task automatic model_clear();
    m_state = 0; m_ovf = 1'b0; m_cnt = 0;
  endtask

  initial begin
    for (int r = 0; r < H; r++) m_rows[r] = '0;

    // 1: reset, counting frame
    tick(); tick();
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_status", {21'b0, img_ready, busy, overflow, byte_count}, 32'h0);
    rst_n = 1'b1;
    expect_status("idle_status");
    send_frame(0, NB);
    expect_status("t1_full_status");
    expect_row(0, "t1_row0_const", 32'h00010203);
    expect_row(31, "t1_row31_const", 32'h7C7D7E7F);
    expect_row(7, "t1_row7", m_rows[7]);

    // 2: junk before header is dropped
    consume();
    send(8'h3C, 1);
    send(8'h00, 2);
    expect_status("t2_idle_after_junk");
    send_frame(1, NB);
    expect_status("t2_full_status");
    check_all_rows("t2_row");

    // 3: overflow, consume, all-ones frame
    send(8'hFF, 1);
    expect_status("t3_overflow_status");
    expect_row(0, "t3_row0_unchanged", m_rows[0]);
    consume();
    expect_status("t3_after_consume");
    send_frame(2, NB);
    for (int r = 0; r < H; r += 5) expect_row(r, "t3_ones_row", 32'hFFFFFFFF);

    // 4: held rx_valid gives one event per byte
    consume();
    send(8'hA5, 5);
    for (int k = 0; k < 6; k++) begin
      send(8'($urandom), 5);
      expect_status("t4_count_held");
    end
    for (int k = 6; k < NB; k++) send(8'($urandom), $urandom_range(1, 2));
    expect_status("t4_full_status");
    check_all_rows("t4_row");

    // 5: clear mid-frame, then reset mid-frame
    consume();
    send_frame(1, 40);
    expect_status("t5_partial");
    clear = 1'b1; tick(); clear = 1'b0;
    model_clear();
    expect_status("t5_after_clear");
    send_frame(1, NB);
    expect_status("t5_full_after_clear");
    check_all_rows("t5_row");
    consume();
    send_frame(1, 40);
    rst_n = 1'b0; tick();
    chk("t5_rst_rd_data", rd_data, 32'h0);
    rst_n = 1'b1;
    model_clear();
    expect_status("t5_after_reset");
    send_frame(1, NB);
    expect_status("t5_full_after_reset");
    check_all_rows("t5r_row");

    // 6: byte event coincident with consume while full
    rx_data = 8'h11; rx_valid = 1'b1; tick();
    img_consume = 1'b1; rx_valid = 1'b0; tick();
    img_consume = 1'b0; tick();
    model_clear();
    expect_status("t6_consume_wins");
    send(8'hA5, 1);
    expect_status("t6_new_frame");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    tick(); tick();
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
